// File: rtl/seq_multiplier_if.sv
// Handshake and operand bus of the sequential multiplier.
// The master drives the request; the slave (the multiplier) returns busy/done/product.
interface seq_multiplier_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic            kill;
  logic [2:0]      MULControl;
  logic            is_word;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] product;

  modport master (
    output start, kill, MULControl, is_word, rs1, rs2,
    input  busy, done, product
  );

  modport slave (
    input  start, kill, MULControl, is_word, rs1, rs2,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier (MUL/MULH/MULHU/MULHSU/MULW), BPC multiplier bits per cycle.
// Handshake: start is taken only in IDLE when kill is low; done pulses for one cycle with product valid.
module seq_multiplier #(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_multiplier_if.slave     bus,
  output logic [1:0]          dbg_state
);

  localparam int W2        = 2 * XLEN;
  localparam int ITER_FULL = XLEN / BPC;
  localparam int ITER_WORD = 32 / BPC;
  localparam int CW        = $clog2(ITER_FULL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W2-1:0]   mcand;
  logic [XLEN-1:0] mplier;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   acc_sum;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            word_q;
  logic            high_q;
  logic [XLEN-1:0] product_q;
  logic [XLEN-1:0] result_sel;
  logic [XLEN-1:0] word_res;

  logic            accept;
  logic            word_mode;
  logic            a_signed, b_signed, a_neg, b_neg, zero_in;
  logic [XLEN-1:0] a_w, b_w, a_ext, b_ext, a_mag, b_mag;

  // Operand conditioning at acceptance: word extension, signedness, magnitudes.
  always_comb begin
    accept    = (state == IDLE) && bus.start && !bus.kill;
    word_mode = bus.is_word && (bus.MULControl == 3'b100) && (XLEN == 64);
    a_w       = XLEN'($signed(bus.rs1[31:0]));
    b_w       = XLEN'($signed(bus.rs2[31:0]));
    a_ext     = word_mode ? a_w : bus.rs1;
    b_ext     = word_mode ? b_w : bus.rs2;
    a_signed  = (bus.MULControl != 3'b110);
    b_signed  = !bus.MULControl[1];
    a_neg     = a_signed && a_ext[XLEN-1];
    b_neg     = b_signed && b_ext[XLEN-1];
    a_mag     = a_neg ? -a_ext : a_ext;
    b_mag     = b_neg ? -b_ext : b_ext;
    zero_in   = (a_ext == '0) || (b_ext == '0) || !bus.MULControl[2];
  end

  always_comb begin
    acc_sum = acc;
    for (int i = 0; i < BPC; i++) begin
      if (mplier[i]) acc_sum = acc_sum + (mcand << i);
    end
  end

  always_comb begin
    word_res   = XLEN'($signed(acc[31:0]));
    result_sel = word_q ? word_res : (high_q ? acc[W2-1:XLEN] : acc[XLEN-1:0]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (bus.kill) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; a kill in DONE suppresses the pulse and leaves the held product alone.
  always_comb begin
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE) && !bus.kill;
    bus.product = bus.done ? result_sel : product_q;
    dbg_state   = state;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      word_q    <= 1'b0;
      high_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= W2'(a_mag);
            mplier <= zero_in ? '0 : b_mag;
            acc    <= '0;
            neg    <= zero_in ? 1'b0 : (a_neg ^ b_neg);
            cnt    <= zero_in ? '0 : (word_mode ? CW'(ITER_WORD - 1) : CW'(ITER_FULL - 1));
            word_q <= word_mode;
            high_q <= (bus.MULControl != 3'b100);
          end
        end
        CALC: begin
          if (!bus.kill) begin
            // Sign is applied once, on the edge that leaves CALC.
            acc    <= (cnt == '0 && neg) ? -acc_sum : acc_sum;
            mcand  <= mcand << BPC;
            mplier <= mplier >> BPC;
            cnt    <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!bus.kill) product_q <= result_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench: two instances (BPC=1 and BPC=4) share one stimulus stream and are
// checked against hand-computed products and completion cycles.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start, kill, is_word;
  logic [2:0]  op;
  logic [63:0] rs1, rs2;
  logic [1:0]  st1, st4;
  int          checks;
  int          errors;

  seq_multiplier_if #(.XLEN(64)) b1 ();
  seq_multiplier_if #(.XLEN(64)) b4 ();

  assign b1.start = start;  assign b4.start = start;
  assign b1.kill = kill;    assign b4.kill = kill;
  assign b1.MULControl = op; assign b4.MULControl = op;
  assign b1.is_word = is_word; assign b4.is_word = is_word;
  assign b1.rs1 = rs1;      assign b4.rs1 = rs1;
  assign b1.rs2 = rs2;      assign b4.rs2 = rs2;

  seq_multiplier #(.XLEN(64), .BPC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave), .dbg_state(st1));
  seq_multiplier #(.XLEN(64), .BPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave), .dbg_state(st4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((b1.busy || b4.busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle_timeout", 64'(n >= 200), 64'd0);
  endtask

  // One operation on both instances: completion cycle counted from the accepting edge.
  task automatic run(input string tag, input logic [2:0] op_i, input logic w_i,
                     input logic [63:0] a_i, input logic [63:0] b_i, input logic [63:0] exp_p,
                     input int ec1, input int ec4);
    int c1, c4, k;
    logic [63:0] p1, p4;
    wait_idle();
    op = op_i; is_word = w_i; rs1 = a_i; rs2 = b_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c1 = -1; c4 = -1; p1 = '0; p4 = '0; k = 1;
    while ((c1 < 0 || c4 < 0) && k <= 200) begin
      if (k == 1) chk({tag, "_busy1"}, 64'(b1.busy), 64'd1);
      if (b1.done && c1 < 0) begin c1 = k; p1 = b1.product; end
      if (b4.done && c4 < 0) begin c4 = k; p4 = b4.product; end
      if (c1 < 0 || c4 < 0) begin
        // Scramble inputs mid-flight and poke a start that must be ignored.
        rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
        op = 3'($urandom_range(0, 7)); is_word = 1'($urandom_range(0, 1));
        start = (k == 3 && ec4 > 4);
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    chk({tag, "_cyc1"}, 64'(c1), 64'(ec1));
    chk({tag, "_prod1"}, p1, exp_p);
    chk({tag, "_cyc4"}, 64'(c4), 64'(ec4));
    chk({tag, "_prod4"}, p4, exp_p);
    chk({tag, "_hold4"}, b4.product, exp_p);
  endtask

  initial begin
    int seen;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; is_word = 1'b0; op = 3'b000;
    rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'({b1.busy, b4.busy}), 64'd0);
    chk("reset_done", 64'({b1.done, b4.done}), 64'd0);
    chk("reset_prod1", b1.product, 64'd0);
    chk("reset_prod4", b4.product, 64'd0);
    rst_n = 1'b1;

    run("mul_3_m2",     3'b100, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 65, 17);
    run("mulhu_ones",   3'b110, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 17);
    run("mulhsu_ones",  3'b111, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 17);
    run("mulh_ones",    3'b101, 1'b0, '1, '1, 64'd0, 65, 17);
    run("mulw_7fff",    3'b100, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 9);
    run("mulw_junk",    3'b100, 1'b1, 64'hDEAD_BEEF_0000_0005, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1, 33, 9);
    run("mul_rs2_zero", 3'b100, 1'b0, 64'h1234, 64'd0, 64'd0, 2, 2);
    run("mulh_rs1_zero",3'b101, 1'b0, 64'd0, 64'h55, 64'd0, 2, 2);
    run("invalid_op",   3'b011, 1'b0, 64'd5, 64'd7, 64'd0, 2, 2);
    run("mulh_minmin",  3'b101, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65, 17);
    run("mulhu_2p65",   3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65, 17);
    run("mul_plain",    3'b100, 1'b0, 64'h1_2345_6789, 64'h10, 64'h12_3456_7890, 65, 17);
    run("mul_5x7",      3'b100, 1'b0, 64'd5, 64'd7, 64'd35, 65, 17);

    // kill during cycle 10 of a MUL
    wait_idle();
    op = 3'b100; is_word = 1'b0; rs1 = 64'h1111; rs2 = 64'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seen = 0;
    for (int k = 1; k <= 10; k++) begin
      if (b1.done || b4.done) seen = 1;
      if (k == 10) kill = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (b1.done || b4.done) seen = 1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_no_done", 64'(seen), 64'd0);
    chk("kill_busy", 64'({b1.busy, b4.busy}), 64'd0);
    chk("kill_prod1", b1.product, 64'd35);
    chk("kill_prod4", b4.product, 64'd35);
    @(posedge clk); #1;
    run("kill_restart", 3'b100, 1'b0, 64'h1111, 64'd3, 64'h3333, 65, 17);

    // start and kill together in IDLE
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; op = 3'b100; rs1 = 64'd9; rs2 = 64'd9;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("startkill_busy", 64'({b1.busy, b4.busy}), 64'd0);
    chk("startkill_prod", b1.product, 64'h3333);

    // reset during cycle 20 of a MULH
    wait_idle();
    op = 3'b101; is_word = 1'b0; rs1 = 64'h7777; rs2 = 64'h99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    chk("pre_reset_busy1", 64'(b1.busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_busy", 64'({b1.busy, b4.busy}), 64'd0);
    chk("rst_done", 64'({b1.done, b4.done}), 64'd0);
    chk("rst_prod1", b1.product, 64'd0);
    chk("rst_prod4", b4.product, 64'd0);
    run("post_reset_mul", 3'b100, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 65, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
